// File: rtl/riscv_dbg_pkg.sv
// Shared debug-path definitions: the dump sequencer state encoding,
// the frame sync byte, and the index byte layout.
package riscv_dbg_pkg;

    localparam int unsigned RF_ADDR_W      = 5;
    localparam logic [7:0]  DUMP_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        IDX,
        LOAD,
        SEND,
        DONE
    } dump_state_e;

    // Index marker byte that precedes a register when indexed framing is built in.
    function automatic logic [7:0] idx_byte(input logic [RF_ADDR_W-1:0] idx);
        return {3'b000, idx};
    endfunction

endpackage

// File: rtl/dump_byte_serializer.sv
// Holds one register word and hands it out LSB-first, one byte per shift,
// flagging the final byte of the word.
module dump_byte_serializer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              shift_i,
    output logic [7:0]        next_byte_o,
    output logic              last_o
);

    localparam int unsigned     NUM_BYTES = DATA_W / 8;
    localparam int unsigned     CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    logic [DATA_W-1:0] word_q;
    logic [DATA_W-1:0] word_d;
    logic [DATA_W-1:0] shifted;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;

    // The byte on the wire is word_q[7:0]; the one after it sits just above.
    assign shifted     = word_q >> 8;
    assign next_byte_o = shifted[7:0];
    assign last_o      = (cnt_q == LAST_CNT);

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        if (load_i) begin
            word_d = word_i;
            cnt_d  = '0;
        end else if (shift_i) begin
            word_d = shifted;
            cnt_d  = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_q <= '0;
            cnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/regfile_dump_sequencer.sv
// Dumps every architectural register over the debug UART byte stream while
// stalling the core. Define DUMP_INDEX_EN to prefix each register with its index.
module regfile_dump_sequencer
    import riscv_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS  = 32,
    parameter int unsigned DATA_W    = 32,
    parameter logic [7:0]  SYNC_BYTE = DUMP_SYNC_BYTE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dump_req,
    output logic [RF_ADDR_W-1:0] rf_addr,
    input  logic [DATA_W-1:0]    rf_data,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 stall_req,
    output logic                 busy,
    output logic                 dump_done
);

    localparam logic [RF_ADDR_W-1:0] LAST_IDX = RF_ADDR_W'(NUM_REGS - 1);

    dump_state_e          state_q;
    logic [RF_ADDR_W-1:0] idx_q;
    logic [7:0]           tx_data_q;
    logic                 tx_valid_q;
    logic                 busy_q;
    logic                 stall_q;
    logic                 done_q;

    logic                 accept;
    logic                 ser_load;
    logic                 ser_shift;
    logic [7:0]           ser_next_byte;
    logic                 ser_last;

    assign accept    = tx_valid_q && tx_ready;
    assign ser_load  = (state_q == LOAD);
    assign ser_shift = (state_q == SEND) && accept;

    dump_byte_serializer #(
        .DATA_W (DATA_W)
    ) u_ser (
        .clk         (clk),
        .reset       (reset),
        .load_i      (ser_load),
        .word_i      (rf_data),
        .shift_i     (ser_shift),
        .next_byte_o (ser_next_byte),
        .last_o      (ser_last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            stall_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (dump_req) begin
                        state_q    <= SYNC;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        stall_q    <= 1'b1;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= SYNC_BYTE;
                    end
                end
                SYNC: begin
                    if (accept) begin
`ifdef DUMP_INDEX_EN
                        state_q   <= IDX;
                        tx_data_q <= idx_byte(idx_q);
`else
                        state_q    <= LOAD;
                        tx_valid_q <= 1'b0;
`endif
                    end
                end
                IDX: begin
                    if (accept) begin
                        state_q    <= LOAD;
                        tx_valid_q <= 1'b0;
                    end
                end
                // The serializer captures rf_data this same cycle; byte 0 goes straight out.
                LOAD: begin
                    state_q    <= SEND;
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= rf_data[7:0];
                end
                SEND: begin
                    if (accept) begin
                        if (!ser_last) begin
                            tx_data_q <= ser_next_byte;
                        end else if (idx_q == LAST_IDX) begin
                            state_q    <= DONE;
                            tx_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            idx_q <= idx_q + RF_ADDR_W'(1);
`ifdef DUMP_INDEX_EN
                            state_q   <= IDX;
                            tx_data_q <= idx_byte(idx_q + RF_ADDR_W'(1));
`else
                            state_q    <= LOAD;
                            tx_valid_q <= 1'b0;
`endif
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    idx_q   <= '0;
                    busy_q  <= 1'b0;
                    stall_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rf_addr   = idx_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign busy      = busy_q;
    assign stall_req = stall_q;
    assign dump_done = done_q;

`ifndef SYNTHESIS
    a_tx_hold: assert property (@(posedge clk) disable iff (reset)
        (tx_valid_q && !tx_ready) |=> (tx_valid_q && $stable(tx_data_q)));
    a_stall_tracks_busy: assert property (@(posedge clk) disable iff (reset)
        stall_q == busy_q);
`endif

endmodule

// File: tb/tb_regfile_dump_sequencer.sv
// Randomized bench for regfile_dump_sequencer: a reference frame builder feeds a
// byte scoreboard that a negedge monitor drains on every accepted byte.
module tb_regfile_dump_sequencer;

    localparam int unsigned NUM_REGS      = 32;
    localparam int unsigned DATA_W        = 32;
    localparam int unsigned BYTES_PER_REG = DATA_W / 8;
`ifdef DUMP_INDEX_EN
    localparam int unsigned IDX_BYTES     = 1;
`else
    localparam int unsigned IDX_BYTES     = 0;
`endif
    localparam int unsigned FRAME_LEN     = 1 + NUM_REGS * (IDX_BYTES + BYTES_PER_REG);
    localparam int          FRAME_BUDGET  = 4000;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              dump_req = 1'b0;
    logic [4:0]        rf_addr;
    logic [DATA_W-1:0] rf_data;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready = 1'b0;
    logic              stall_req;
    logic              busy;
    logic              dump_done;

    logic [DATA_W-1:0] regs [NUM_REGS];
    assign rf_data = regs[rf_addr];

    regfile_dump_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .dump_req  (dump_req),
        .rf_addr   (rf_addr),
        .rf_data   (rf_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .stall_req (stall_req),
        .busy      (busy),
        .dump_done (dump_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 0: always ready, 1: ready about 30% of cycles, 2: never ready
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ($urandom_range(99) < 30);
            default: tx_ready = 1'b0;
        endcase
    end

    // Reference frame: sync byte, then each register (optionally index-prefixed) LSB first.
    logic [7:0] exp_q [$];
    task automatic push_frame();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < NUM_REGS; i++) begin
`ifdef DUMP_INDEX_EN
            exp_q.push_back(8'(i));
`endif
            for (int b = 0; b < BYTES_PER_REG; b++)
                exp_q.push_back(8'(regs[i] >> (8 * b)));
        end
    endtask

    int         bytes_in_frame = 0;
    int         frames_done    = 0;
    bit         hold_pending   = 0;
    logic [7:0] hold_data      = '0;
    bit         done_expected  = 0;
    bit         done_prev      = 0;
    bit         busy_prev      = 0;

    always @(negedge clk) begin
        logic [7:0] e;
        if (reset) begin
            exp_q.delete();
            bytes_in_frame = 0;
            hold_pending   = 0;
            done_expected  = 0;
            done_prev      = 0;
            busy_prev      = 0;
        end else begin
            // The snapshot is the regfile as it stands when the core gets stalled.
            if (busy && !busy_prev) begin
                push_frame();
                bytes_in_frame = 0;
            end
            check_eq("stall_eq_busy", 32'(stall_req), 32'(busy));
            check_eq("dump_done", 32'(dump_done), 32'(done_expected));
            if (dump_done) begin
                check_eq("frame_len", 32'(bytes_in_frame), 32'(FRAME_LEN));
                frames_done++;
            end
            if (done_prev)
                check_eq("idle_after_done", 32'(busy), 32'd0);
            if (hold_pending) begin
                check_eq("hold_valid", 32'(tx_valid), 32'd1);
                check_eq("hold_data", 32'(tx_data), 32'(hold_data));
            end
            done_expected = 0;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_byte: got %0h expected no byte", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check_eq($sformatf("byte%0d", bytes_in_frame), 32'(tx_data), 32'(e));
                end
                bytes_in_frame++;
                done_expected = (bytes_in_frame == int'(FRAME_LEN));
            end
            hold_pending = tx_valid && !tx_ready;
            hold_data    = tx_data;
            busy_prev    = busy;
            done_prev    = dump_done;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < FRAME_BUDGET) begin
            tick();
            n++;
        end
        if (frames_done < target) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_timeout: frames %0d expected %0d", frames_done, target);
        end
    endtask

    task automatic run_dump();
        int fr = frames_done;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        wait_frames(fr + 1);
        repeat (3) tick();
    endtask

    task automatic randomize_regs();
        for (int i = 1; i < NUM_REGS; i++) regs[i] = $urandom;
    endtask

    initial begin
        int fr;
        int n;
        int blocked;
        for (int i = 0; i < NUM_REGS; i++) regs[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("rst_tx_data", 32'(tx_data), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_stall", 32'(stall_req), 32'd0);
        check_eq("rst_done", 32'(dump_done), 32'd0);
        check_eq("rst_rf_addr", 32'(rf_addr), 32'd0);
        reset = 1'b0;
        repeat (2) tick();

        // Known ramp pattern with an always-ready UART.
        for (int i = 1; i < NUM_REGS; i++) regs[i] = 32'h0000_0100 + 32'(i);
        ready_mode = 0;
        run_dump();

        // UART stuck not-ready: sync byte must sit on the wire with the core stalled.
        randomize_regs();
        ready_mode = 2;
        repeat (2) tick();
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        repeat (40) tick();
        check_eq("stuck_busy", 32'(busy), 32'd1);
        check_eq("stuck_stall", 32'(stall_req), 32'd1);
        check_eq("stuck_valid", 32'(tx_valid), 32'd1);
        check_eq("stuck_data", 32'(tx_data), 32'hA5);
        fr = frames_done;
        ready_mode = 1;
        wait_frames(fr + 1);
        repeat (3) tick();

        // dump_req held across a whole dump: exactly two back-to-back frames.
        randomize_regs();
        ready_mode = 1;
        fr = frames_done;
        dump_req = 1'b1;
        wait_frames(fr + 1);
        n = 0;
        while (!busy && n < 10) begin
            tick();
            n++;
        end
        check_eq("rearm_busy", 32'(busy), 32'd1);
        dump_req = 1'b0;
        wait_frames(fr + 2);
        repeat (10) tick();
        check_eq("held_frames", 32'(frames_done - fr), 32'd2);
        check_eq("held_idle", 32'(busy), 32'd0);

        // Reset while byte 40 is presented: outputs drop without a clock edge.
        randomize_regs();
        ready_mode = 1;
        fr = frames_done;
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(bytes_in_frame == 39 && tx_valid) && n < FRAME_BUDGET);
        check_eq("byte40_reached", 32'(bytes_in_frame), 32'd39);
        reset = 1'b1;
        #1;
        check_eq("async_tx_valid", 32'(tx_valid), 32'd0);
        check_eq("async_busy", 32'(busy), 32'd0);
        check_eq("async_stall", 32'(stall_req), 32'd0);
        check_eq("async_done", 32'(dump_done), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        check_eq("abandoned_no_done", 32'(frames_done), 32'(fr));
        run_dump();

        // A recognisable word in x5, random backpressure.
        randomize_regs();
        regs[5] = 32'hDEAD_BEEF;
        ready_mode = 1;
        run_dump();

        // Core keeps trying to write; writes only land while stall_req is low.
        ready_mode = 1;
        randomize_regs();
        fr = frames_done;
        blocked = 0;
        repeat (3) begin
            regs[$urandom_range(NUM_REGS - 1, 1)] = $urandom;
            tick();
        end
        dump_req = 1'b1;
        tick();
        dump_req = 1'b0;
        n = 0;
        while (frames_done < fr + 1 && n < FRAME_BUDGET) begin
            if (stall_req) blocked++;
            else regs[$urandom_range(NUM_REGS - 1, 1)] = $urandom;
            tick();
            n++;
        end
        check_eq("snapshot_frame", 32'(frames_done), 32'(fr + 1));
        check_eq("writes_held_off", 32'(blocked > 0), 32'd1);
        repeat (5) tick();

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("final_busy", 32'(busy), 32'd0);
        check_eq("final_rf_addr", 32'(rf_addr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
